// File: rtl/adder_tree_pkg.sv
// Shared constants and state type for the adder-tree host and engine.
// Optional self-check is enabled in the host by ADDER_TREE_HOST_CHECK_EN.
package adder_tree_pkg;

    localparam int WORD_W  = 16;
    localparam int N_WORDS = 8;
    localparam int TIMEOUT = 64;
    localparam int DIN_W   = WORD_W * N_WORDS;

    typedef enum logic [1:0] {
        FILL,
        START,
        WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/adder_tree_host_wait_timer.sv
// Clearable up-counter for the host's WAIT timeout.
// Terminal count flags LIMIT-1 cycles spent waiting.
module wait_timer
    import adder_tree_pkg::*;
#(
    parameter int LIMIT = TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam int CW = $clog2(LIMIT);
    localparam logic [CW-1:0] TC = CW'(LIMIT - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !o_tc) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tc = (r_cnt == TC);

endmodule

// File: rtl/adder_tree_host.sv
// Initiator for the adder-tree engine: packs operands, starts, awaits done.
// Define ADDER_TREE_HOST_CHECK_EN to compare the engine sum to a local sum.
module adder_tree_host
    import adder_tree_pkg::*;
#(
    parameter int WORD_W  = adder_tree_pkg::WORD_W,
    parameter int N_WORDS = adder_tree_pkg::N_WORDS,
    parameter int TIMEOUT = adder_tree_pkg::TIMEOUT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WORD_W-1:0]         in_data,
    output logic                      start,
    output logic [WORD_W*N_WORDS-1:0] din,
    input  logic                      done,
    input  logic [WORD_W-1:0]         dout,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [WORD_W-1:0]         res_data,
    output logic                      res_err,
    output logic                      res_mismatch,
    output logic                      busy
);

    localparam int CW = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam logic [CW-1:0] LAST = CW'(N_WORDS - 1);

    state_t r_state;
    state_t w_next;

    logic [CW-1:0]             r_cnt;
    logic [WORD_W*N_WORDS-1:0] r_din;
    logic [WORD_W-1:0]         r_res_data;
    logic                      r_res_err;

    logic w_accept;
    logic w_timer_clr;
    logic w_timer_en;
    logic w_tc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= FILL;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_accept    = 1'b0;
        w_timer_clr = 1'b0;
        w_timer_en  = 1'b0;
        unique case (r_state)
            FILL: begin
                w_accept = in_valid;
                if (in_valid && (r_cnt == LAST)) begin
                    w_next = START;
                end
            end
            START: begin
                w_timer_clr = 1'b1;
                w_next      = WAIT;
            end
            WAIT: begin
                if (done || w_tc) begin
                    w_next = RESP;
                end else begin
                    w_timer_en = 1'b1;
                end
            end
            RESP: begin
                if (res_ready) begin
                    w_next = FILL;
                end
            end
            default: w_next = FILL;
        endcase
    end

    // din only changes in FILL, so it is stable while the engine works
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_din      <= '0;
            r_res_data <= '0;
            r_res_err  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_din[r_cnt*WORD_W +: WORD_W] <= in_data;
                r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
            end
            if (r_state == WAIT) begin
                if (done) begin
                    r_res_data <= dout;
                    r_res_err  <= 1'b0;
                end else if (w_tc) begin
                    r_res_data <= '0;
                    r_res_err  <= 1'b1;
                end
            end
        end
    end

    wait_timer #(
        .LIMIT (TIMEOUT)
    ) u_wait_timer (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_timer_clr),
        .i_en  (w_timer_en),
        .o_tc  (w_tc)
    );

`ifdef ADDER_TREE_HOST_CHECK_EN
    logic [WORD_W-1:0] r_sum;
    logic              r_res_mis;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum     <= '0;
            r_res_mis <= 1'b0;
        end else begin
            if ((r_state == RESP) && res_ready) begin
                r_sum <= '0;
            end else if (w_accept) begin
                r_sum <= r_sum + in_data;
            end
            if (r_state == WAIT) begin
                if (done) begin
                    r_res_mis <= (dout != r_sum);
                end else if (w_tc) begin
                    r_res_mis <= 1'b0;
                end
            end
        end
    end

    assign res_mismatch = r_res_mis;
`else
    assign res_mismatch = 1'b0;
`endif

    assign in_ready  = (r_state == FILL);
    assign start     = (r_state == START);
    assign busy      = (r_state == START) || (r_state == WAIT);
    assign res_valid = (r_state == RESP);
    assign res_data  = r_res_data;
    assign res_err   = r_res_err;
    assign din       = r_din;

endmodule

// File: tb/tb_adder_tree_host.sv
// Randomized self-checking bench for adder_tree_host with a behavioural
// engine partner and a transaction-level reference model.
module tb_adder_tree_host;

    localparam int W  = 16;
    localparam int N  = 8;
    localparam int TO = 64;
`ifdef ADDER_TREE_HOST_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   in_data = '0;
    logic           start;
    logic [W*N-1:0] din;
    logic           done = 1'b0;
    logic [W-1:0]   dout = '0;
    logic           res_valid;
    logic           res_ready = 1'b0;
    logic [W-1:0]   res_data;
    logic           res_err;
    logic           res_mismatch;
    logic           busy;

    int checks = 0;
    int errors = 0;

    adder_tree_host #(
        .WORD_W  (W),
        .N_WORDS (N),
        .TIMEOUT (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .start        (start),
        .din          (din),
        .done         (done),
        .dout         (dout),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .res_err      (res_err),
        .res_mismatch (res_mismatch),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Engine partner: 0 = correct sum, 1 = never done, 2 = sum+1
    int           eng_mode  = 0;
    bit           eng_stray = 1'b0;
    int           eng_cnt   = 0;
    logic [W-1:0] eng_val   = '0;

    initial begin
        logic           s;
        logic [W*N-1:0] lat;
        logic [W-1:0]   acc;
        forever begin
            @(posedge clk);
            s   = start;
            lat = din;
            #1;
            done = 1'b0;
            if (eng_cnt > 0) begin
                eng_cnt--;
                if (eng_cnt == 0) begin
                    done = 1'b1;
                    dout = eng_val;
                end
            end else if (eng_stray) begin
                done      = 1'b1;
                dout      = 16'hBEEF;
                eng_stray = 1'b0;
            end
            if (s && eng_mode != 1) begin
                acc = '0;
                for (int k = 0; k < N; k++) acc += lat[k*W +: W];
                eng_val = acc + ((eng_mode == 2) ? 16'd1 : 16'd0);
                eng_cnt = 4;
            end
        end
    end

    // Reference model: phase 0 fill, 1 start, 2 wait, 3 result
    int           m_ph   = 0;
    logic [W-1:0] m_q[$];
    logic [W*N-1:0] m_din = '0;
    int           m_wait = 0;
    logic [W-1:0] m_data = '0;
    logic         m_err  = 1'b0;
    logic         m_mis  = 1'b0;

    function automatic logic [W-1:0] qsum();
        logic [W-1:0] s = '0;
        foreach (m_q[i]) s += m_q[i];
        return s;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ph   = 0;
            m_q.delete();
            m_din  = '0;
            m_wait = 0;
            m_data = '0;
            m_err  = 1'b0;
            m_mis  = 1'b0;
        end else begin
            case (m_ph)
                0: if (in_valid) begin
                    m_din[m_q.size()*W +: W] = in_data;
                    m_q.push_back(in_data);
                    if (m_q.size() == N) m_ph = 1;
                end
                1: begin
                    m_wait = 0;
                    m_ph   = 2;
                end
                2: if (done) begin
                    m_data = dout;
                    m_err  = 1'b0;
                    m_mis  = CHK ? (dout != qsum()) : 1'b0;
                    m_ph   = 3;
                end else if (m_wait == TO - 1) begin
                    m_data = '0;
                    m_err  = 1'b1;
                    m_mis  = 1'b0;
                    m_ph   = 3;
                end else begin
                    m_wait++;
                end
                default: if (res_ready) begin
                    m_ph = 0;
                    m_q.delete();
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("in_ready", in_ready, m_ph == 0);
            chk("start", start, m_ph == 1);
            chk("busy", busy, m_ph == 1 || m_ph == 2);
            chk("res_valid", res_valid, m_ph == 3);
            chk("din", din, m_din);
            chk("res_data", res_data, m_data);
            chk("res_err", res_err, m_err);
            chk("res_mismatch", res_mismatch, m_mis);
        end
    end

    function automatic logic [W-1:0] vsum(input logic [W-1:0] v[N]);
        logic [W-1:0] s = '0;
        for (int i = 0; i < N; i++) s += v[i];
        return s;
    endfunction

    task automatic send_word(input logic [W-1:0] w);
        int   g = 0;
        logic r;
        in_valid = 1'b1;
        in_data  = w;
        do begin
            @(negedge clk);
            r = in_ready;
            @(posedge clk);
            #1;
            g++;
        end while (!r && g < 200);
        if (!r) chk("send_timeout", 1'b0, 1'b1);
        in_valid = 1'b0;
    endtask

    task automatic send_vec(input logic [W-1:0] v[N], input int gap);
        for (int i = 0; i < N; i++) begin
            send_word(v[i]);
            if (gap > 0 && i < N - 1) begin
                repeat ($urandom_range(gap, 0)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
    endtask

    task automatic get_result(input int delay, output logic [W-1:0] d,
                              output logic e, output logic m,
                              output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!res_valid && lat < 300);
        chk("res_wait", res_valid, 1'b1);
        d = res_data;
        e = res_err;
        m = res_mismatch;
        repeat (delay) begin
            @(posedge clk);
            #1;
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] v[N];
        logic [W-1:0] d;
        logic         e, m;
        int           lat, n;

        @(negedge clk);
        chk("rst_start", start, 1'b0);
        chk("rst_din", din, '0);
        chk("rst_res_valid", res_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_res_data", res_data, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;

        // Words 1..8 with an immediately ready consumer
        for (int i = 0; i < N; i++) v[i] = 16'(i + 1);
        send_vec(v, 0);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!res_valid && lat < 300);
        chk("t1_latency", 32'(lat), 32'd7);
        chk("t1_din", din, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
        chk("t1_sum", res_data, 16'h0024);
        chk("t1_err", res_err, 1'b0);
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;

        // All ones wrap modulo 2^16
        for (int i = 0; i < N; i++) v[i] = 16'hFFFF;
        send_vec(v, 0);
        get_result(0, d, e, m, lat);
        chk("t2_sum", d, 16'hFFF8);
        chk("t2_mis", m, 1'b0);

        // Back-pressure on the result with in_valid held high
        for (int i = 0; i < N; i++) v[i] = 16'($urandom);
        send_vec(v, 0);
        in_valid = 1'b1;
        in_data  = 16'hDEAD;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!res_valid && n < 300);
        chk("t3_sum1", res_data, vsum(v));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t3_hold_valid", res_valid, 1'b1);
            chk("t3_hold_in_ready", in_ready, 1'b0);
        end
        in_valid  = 1'b0;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        for (int i = 0; i < N; i++) v[i] = 16'($urandom);
        send_vec(v, 1);
        get_result(2, d, e, m, lat);
        chk("t3_sum2", d, vsum(v));

        // Engine never answers: timeout, then a stray done in FILL
        eng_mode = 1;
        for (int i = 0; i < N; i++) v[i] = 16'($urandom);
        send_vec(v, 0);
        @(negedge clk);
        chk("t4_start", start, 1'b1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!res_valid && n < 300);
        chk("t4_timeout_cycles", 32'(n), 32'd65);
        chk("t4_err", res_err, 1'b1);
        chk("t4_data", res_data, 16'h0000);
        chk("t4_mis", res_mismatch, 1'b0);
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        eng_mode  = 0;
        eng_stray = 1'b1;
        repeat (3) @(negedge clk);
        chk("t4_stray_ignored", res_valid, 1'b0);
        chk("t4_stray_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;

        // Reset after five words discards the partial vector
        for (int i = 0; i < 5; i++) send_word(16'(10 + i));
        rst = 1'b1;
        @(negedge clk);
        chk("t5_din", din, '0);
        chk("t5_res_valid", res_valid, 1'b0);
        chk("t5_start", start, 1'b0);
        chk("t5_busy", busy, 1'b0);
        chk("t5_res_err", res_err, 1'b0);
        chk("t5_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < N; i++) v[i] = 16'(10 + i);
        send_vec(v, 0);
        get_result(0, d, e, m, lat);
        chk("t5_sum", d, 16'h006C);

        // Engine returns sum+1
        eng_mode = 2;
        for (int i = 0; i < N; i++) v[i] = 16'($urandom);
        send_vec(v, 0);
        get_result(0, d, e, m, lat);
        chk("t6_data", d, vsum(v) + 16'd1);
        chk("t6_err", e, 1'b0);
        chk("t6_mis", m, CHK);

        // Random traffic
        for (int t = 0; t < 20; t++) begin
            n = $urandom_range(9, 0);
            eng_mode = (n == 0) ? 1 : ((n < 4) ? 2 : 0);
            for (int i = 0; i < N; i++) v[i] = 16'($urandom);
            send_vec(v, 3);
            get_result($urandom_range(4, 0), d, e, m, lat);
            if (eng_mode == 1) begin
                chk("rnd_err", e, 1'b1);
                chk("rnd_zero", d, 16'h0000);
            end else begin
                chk("rnd_sum", d, vsum(v) + ((eng_mode == 2) ? 16'd1 : 16'd0));
                chk("rnd_mis", m, CHK && (eng_mode == 2));
            end
        end

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adder_tree_host.md
# adder_tree_host

Initiator for the 8×16-bit adder-tree engine (`adder_tree_fsm`). Collects eight 16-bit words over a valid/ready stream and packs them into the engine's 128-bit `din`. It then issues a single-cycle `start`, waits for `done` under a timeout guard, and returns the 16-bit sum on a valid/ready result port. It sits between the host-facing register/pipe logic and the engine.

## Interface
- `WORD_W`, 16, width of one operand and of the result
- `N_WORDS`, 8, operands per request; `din` is `WORD_W*N_WORDS` bits
- `TIMEOUT`, 64, maximum cycles spent in WAIT before aborting; must be ≥ 8
- `clk` in 1: single clock, rising edge
- `rst` in 1: reset; asynchronous, active-high
- `in_valid` in 1: operand word valid
- `in_ready` out 1: block accepts a word this cycle
- `in_data` in 16: operand word
- `start` out 1: one-cycle request pulse to the engine
- `din` out 128: packed operands; word k occupies bits [16k+15:16k]
- `done` in 1: engine completion strobe
- `dout` in 16: engine sum, sampled when `done`=1
- `res_valid` out 1: result available
- `res_ready` in 1: consumer accepts result
- `res_data` out 16: captured sum
- `res_err` out 1: result produced by timeout; `res_data`=0
- `res_mismatch` out 1: self-check failure (see Configuration)
- `busy` out 1: high in START and WAIT

## Operation
- States: FILL, START, WAIT, RESP. Reset enters FILL.
- **FILL**
  - `in_ready`=1.
  - On `in_valid & in_ready`, write `in_data` into slot `cnt` of `din` and increment `cnt` (0..7).
  - Accepting the word at `cnt`=7 clears `cnt` and moves to START.
- **START**
  - `start`=1 for exactly this cycle, then WAIT.
  - Clear the wait counter.
- **WAIT**
  - `in_ready`=0.
  - `din` is held constant from START until RESP exits.
  - If `done`=1: `res_data`←`dout`, `res_err`←0, go to RESP.
  - Else, if the wait counter equals `TIMEOUT-1`: `res_data`←0, `res_err`←1, go to RESP.
  - Else, increment the wait counter.
  - `done` and the timeout condition in the same cycle: `done` wins.
- **RESP**
  - `res_valid`=1, with `res_data`, `res_err` and `res_mismatch` stable.
  - On `res_ready`, go to FILL; `res_valid` drops the next cycle.
- `done` seen outside WAIT is ignored.
- Words are never accepted outside FILL.
- Arithmetic follows the engine: the sum wraps modulo 2^16, with no saturation and no carry out.
- `rst` mid-operation:
  - All state is discarded and the block returns to FILL with `cnt`=0.
  - A partially filled vector is lost.
  - An engine in flight is not signalled; a later stray `done` is ignored per the rule above.

## Timing
- Reset values:
  - `start`=0, `din`=0, `res_valid`=0, `res_data`=0, `res_err`=0, `res_mismatch`=0, `busy`=0.
  - `in_ready`=1 once `rst` deasserts.
- `start`, `res_*` and `busy` are registered or decoded from the state register only. There is no combinational path from inputs to outputs, except `in_ready`, which is decoded from state.
- Throughput: one word per cycle in FILL.
- Latency with `adder_tree_fsm` as partner:
  - Last word accepted in cycle T → `start` in T+1.
  - Engine `done` in T+6.
  - `res_valid` in T+7.
- Minimum request period: 8 fill cycles + 1 START + 5 WAIT + 1 RESP = 15 cycles.
- Timeout: `res_valid` with `res_err`=1 rises `TIMEOUT`+1 cycles after `start`.

## Configuration
- Controlled by the macro `ADDER_TREE_HOST_CHECK_EN`.
- **Defined:**
  - A 16-bit running sum of accepted words is kept (cleared on reset and on entry to FILL from RESP).
  - On `done`, `res_mismatch`←(`dout` ≠ running sum).
  - On timeout, `res_mismatch`←0.
- **Undefined:**
  - The running-sum logic is absent.
  - `res_mismatch` is tied to 0.
  - The port list is unchanged.

## Structure
- Package `adder_tree_pkg` holds:
  - the state enum (FILL, START, WAIT, RESP);
  - `WORD_W`, `N_WORDS`, and the default `TIMEOUT`;
  - the derived `DIN_W` = `WORD_W*N_WORDS`.
- `adder_tree_fsm` imports the width constants from the same package.
- One sub-module: `wait_timer`, a clearable up-counter with a terminal-count flag for the WAIT timeout.
- The packer and FSM stay in the top module.

## Test plan
- Words 1..8, `res_ready`=1, paired with `adder_tree_fsm` → `din`=0x0008_0007_..._0001, `res_data`=0x0024, `res_err`=0, `res_valid` at T+7.
- Eight words of 0xFFFF → `res_data`=0xFFF8; with CHECK_EN, `res_mismatch`=0.
- Hold `res_ready`=0 for 10 cycles with `in_valid`=1 → `res_valid` held and `in_ready`=0 throughout; after `res_ready`, the next 8 words give a correct second sum.
- Engine model that never asserts `done`, `TIMEOUT`=64 → `res_valid` 65 cycles after `start`, with `res_err`=1 and `res_data`=0; a late `done` pulse in FILL is ignored.
- Assert `rst` after 5 words accepted → all outputs at reset values; a following 8 words (10..17) give `res_data`=0x006C.
- CHECK_EN with the model returning `dout`=sum+1 → `res_mismatch`=1 and `res_err`=0.
